// File: rtl/node_endpoint.sv
// Network endpoint: user word interface on one side, 4-phase request/ack
// flit links to the switch local port on the other, with a 2-deep RX FIFO.
module node_endpoint #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4,
    parameter int ADDR      = 0,
    parameter int CNT_SIZE  = 8,
    localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1
) (
    input  logic                 clk,
    input  logic                 a_rst,
    input  logic                 tx_valid,
    input  logic [ADDR_SIZE-1:0] tx_addr,
    input  logic [DATA_SIZE-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 out_r,
    input  logic                 out_w,
    output logic [BUS_SIZE-1:0]  data_o,
    input  logic                 in_r,
    output logic                 in_w,
    input  logic [BUS_SIZE-1:0]  data_i,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_SIZE-1:0] rx_data,
    output logic [CNT_SIZE-1:0]  drop_cnt
);

    localparam logic [ADDR_SIZE-1:0] OWN_ADDR = ADDR_SIZE'(ADDR);

    typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_state_e;
    typedef enum logic {R_IDLE, R_ACK} rx_state_e;

    tx_state_e            tx_state_q, tx_state_d;
    logic                 out_r_q, out_r_d;
    logic [BUS_SIZE-1:0]  data_o_q, data_o_d;

    rx_state_e            rx_state_q, rx_state_d;
    logic                 in_w_q, in_w_d;
    logic [DATA_SIZE-1:0] mem_q [2];
    logic [DATA_SIZE-1:0] mem_d [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           count_q, count_d;
    logic [CNT_SIZE-1:0]  drop_cnt_q, drop_cnt_d;

    logic cap, flit_ok, push, pop, drop;

    assign tx_ready = (tx_state_q == T_IDLE);
    assign out_r    = out_r_q;
    assign data_o   = data_o_q;
    assign in_w     = in_w_q;
    assign rx_valid = (count_q != 2'd0);
    assign rx_data  = mem_q[rd_ptr_q];
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        tx_state_d = tx_state_q;
        out_r_d    = out_r_q;
        data_o_d   = data_o_q;
        unique case (tx_state_q)
            T_IDLE: if (tx_valid) begin
                data_o_d   = {1'b1, tx_addr, tx_data};
                out_r_d    = 1'b1;
                tx_state_d = T_REQ;
            end
            T_REQ: if (out_w) begin
                out_r_d    = 1'b0;
                tx_state_d = T_REL;
            end
            T_REL: if (!out_w) begin
                tx_state_d = T_IDLE;
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // Capture uses the occupancy seen at this edge, before any same-cycle pop.
    assign flit_ok = data_i[BUS_SIZE-1] && (data_i[DATA_SIZE +: ADDR_SIZE] == OWN_ADDR);
    assign cap     = (rx_state_q == R_IDLE) && in_r && (count_q != 2'd2);
    assign push    = cap && flit_ok;
    assign drop    = cap && !flit_ok;
    assign pop     = rx_valid && rx_ready;

    always_comb begin
        rx_state_d = rx_state_q;
        in_w_d     = in_w_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        drop_cnt_d = drop_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_i[DATA_SIZE-1:0];
        end
        if (drop && (drop_cnt_q != {CNT_SIZE{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_SIZE'(1);
        end
        unique case (rx_state_q)
            R_IDLE: if (cap) begin
                in_w_d     = 1'b1;
                rx_state_d = R_ACK;
            end
            R_ACK: if (!in_r) begin
                in_w_d     = 1'b0;
                rx_state_d = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            tx_state_q <= T_IDLE;
            out_r_q    <= 1'b0;
            data_o_q   <= '0;
            rx_state_q <= R_IDLE;
            in_w_q     <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            drop_cnt_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            out_r_q    <= out_r_d;
            data_o_q   <= data_o_d;
            rx_state_q <= rx_state_d;
            in_w_q     <= in_w_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_node_endpoint.sv
// Directed and randomized checks of node_endpoint (ADDR=3, CNT_SIZE=2)
// against a queue-based model of the TX and RX word streams.
module tb_node_endpoint;

    logic        clk;
    logic        a_rst;
    logic        tx_valid;
    logic [3:0]  tx_addr;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        out_r;
    logic        out_w;
    logic [36:0] data_o;
    logic        in_r;
    logic        in_w;
    logic [36:0] data_i;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] rx_data;
    logic [1:0]  drop_cnt;

    node_endpoint #(
        .DATA_SIZE(32),
        .ADDR_SIZE(4),
        .ADDR(3),
        .CNT_SIZE(2)
    ) dut (
        .clk(clk),
        .a_rst(a_rst),
        .tx_valid(tx_valid),
        .tx_addr(tx_addr),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .out_r(out_r),
        .out_w(out_w),
        .data_o(data_o),
        .in_r(in_r),
        .in_w(in_w),
        .data_i(data_i),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [31:0] rxq [$];
    logic [36:0] txq [$];
    logic [36:0] tx_cur;
    logic [36:0] sw_flit;
    logic        f_v;
    logic [3:0]  f_a;
    int          drop_exp;
    int          sw_st;
    int          sw_wait;
    int          ts;
    int          dly;
    logic        in_w_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_flit(input logic [36:0] f);
        int n;
        @(negedge clk);
        in_r   = 1'b1;
        data_i = f;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_w && n < 50);
        chk("flit_ack", in_w, 1'b1);
        in_r = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (in_w && n < 50);
        chk("flit_rel", in_w, 1'b0);
    endtask

    initial begin
        a_rst    = 1'b1;
        tx_valid = 1'b0;
        tx_addr  = '0;
        tx_data  = '0;
        out_w    = 1'b0;
        in_r     = 1'b0;
        data_i   = '0;
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_r", out_r, 1'b0);
        chk("rst_in_w", in_w, 1'b0);
        chk("rst_data_o", data_o, 37'h0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_drop", drop_cnt, 2'd0);
        a_rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1'b1);

        // TX handshake with the switch acking two cycles after the request
        tx_valid = 1'b1;
        tx_addr  = 4'd5;
        tx_data  = 32'hA5A5A5A5;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx_req", out_r, 1'b1);
        chk("tx_flit", data_o, 37'h15A5A5A5A5);
        chk("tx_busy", tx_ready, 1'b0);
        @(negedge clk);
        chk("tx_req2", out_r, 1'b1);
        chk("tx_flit2", data_o, 37'h15A5A5A5A5);
        out_w = 1'b1;
        @(negedge clk);
        chk("tx_req_fall", out_r, 1'b0);
        chk("tx_rel_busy", tx_ready, 1'b0);
        chk("tx_flit3", data_o, 37'h15A5A5A5A5);
        out_w = 1'b0;
        @(negedge clk);
        chk("tx_ready_back", tx_ready, 1'b1);

        // RX accepted flit
        in_r   = 1'b1;
        data_i = {1'b1, 4'd3, 32'h12345678};
        @(negedge clk);
        chk("rx_ack", in_w, 1'b1);
        chk("rx_valid", rx_valid, 1'b1);
        chk("rx_data", rx_data, 32'h12345678);
        in_r = 1'b0;
        @(negedge clk);
        chk("rx_ack_fall", in_w, 1'b0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("rx_popped", rx_valid, 1'b0);

        // Drops: wrong address, clear valid bit, then saturation at 3
        send_flit({1'b1, 4'd7, 32'hDEAD0001});
        chk("drop_rx_valid", rx_valid, 1'b0);
        chk("drop_1", drop_cnt, 2'd1);
        send_flit({1'b0, 4'd3, 32'hDEAD0002});
        chk("drop_2", drop_cnt, 2'd2);
        send_flit({1'b1, 4'd7, 32'hDEAD0003});
        send_flit({1'b1, 4'd7, 32'hDEAD0004});
        send_flit({1'b1, 4'd7, 32'hDEAD0005});
        chk("drop_sat", drop_cnt, 2'd3);
        chk("drop_rx_valid2", rx_valid, 1'b0);

        // Backpressure on a full FIFO
        send_flit({1'b1, 4'd3, 32'hAAAA0001});
        send_flit({1'b1, 4'd3, 32'hAAAA0002});
        @(negedge clk);
        in_r   = 1'b1;
        data_i = {1'b1, 4'd3, 32'hAAAA0003};
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold", in_w, 1'b0);
        end
        chk("bp_head", rx_data, 32'hAAAA0001);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("bp_post_pop", in_w, 1'b0);
        chk("bp_head2", rx_data, 32'hAAAA0002);
        @(negedge clk);
        chk("bp_ack", in_w, 1'b1);
        in_r = 1'b0;
        @(negedge clk);
        chk("bp_rel", in_w, 1'b0);
        chk("bp_order2", rx_data, 32'hAAAA0002);
        rx_ready = 1'b1;
        @(negedge clk);
        chk("bp_order3", rx_data, 32'hAAAA0003);
        @(negedge clk);
        rx_ready = 1'b0;
        chk("bp_empty", rx_valid, 1'b0);

        // Reset in the middle of both handshakes
        tx_valid = 1'b1;
        tx_addr  = 4'd2;
        tx_data  = 32'h11112222;
        in_r     = 1'b1;
        data_i   = {1'b1, 4'd3, 32'h0000BEEF};
        @(negedge clk);
        tx_valid = 1'b0;
        chk("mid_out_r", out_r, 1'b1);
        chk("mid_in_w", in_w, 1'b1);
        chk("mid_rx_valid", rx_valid, 1'b1);
        a_rst = 1'b1;
        @(negedge clk);
        chk("mrst_out_r", out_r, 1'b0);
        chk("mrst_in_w", in_w, 1'b0);
        chk("mrst_rx_valid", rx_valid, 1'b0);
        chk("mrst_drop", drop_cnt, 2'd0);
        chk("mrst_data_o", data_o, 37'h0);
        a_rst = 1'b0;
        in_r  = 1'b0;
        @(negedge clk);
        chk("mrst_tx_ready", tx_ready, 1'b1);
        chk("mrst_out_r2", out_r, 1'b0);

        // Randomized concurrent traffic
        drop_exp  = 0;
        sw_st     = 0;
        sw_wait   = 0;
        ts        = 0;
        dly       = 0;
        in_w_prev = 1'b0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge clk);
            if (in_w && !in_w_prev) begin
                if (sw_flit[36] && sw_flit[35:32] == 4'd3) rxq.push_back(sw_flit[31:0]);
                else if (drop_exp < 3) drop_exp++;
                chk("r_drop", drop_cnt, 64'(drop_exp));
            end
            in_w_prev = in_w;
            chk("r_rx_valid", rx_valid, 64'(rxq.size() != 0));
            rx_ready = 1'($urandom_range(0, 1));
            if (rx_valid && rx_ready && rxq.size() != 0) begin
                chk("r_rx_data", rx_data, rxq.pop_front());
            end

            if (sw_st == 0) begin
                data_i = {5'($urandom), 32'($urandom)};
                if (cyc < 2200 && $urandom_range(0, 2) == 0) begin
                    f_v     = ($urandom_range(0, 4) != 0);
                    f_a     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd3;
                    sw_flit = {f_v, f_a, 32'($urandom)};
                    in_r    = 1'b1;
                    data_i  = sw_flit;
                    sw_st   = 1;
                    sw_wait = 0;
                end
            end else if (sw_st == 1) begin
                sw_wait++;
                if (in_w) begin
                    if ($urandom_range(0, 1) == 0) begin
                        in_r    = 1'b0;
                        sw_st   = 2;
                        sw_wait = 0;
                    end
                end else if (sw_wait > 100) begin
                    chk("r_ack_timeout", in_w, 1'b1);
                    in_r  = 1'b0;
                    sw_st = 2;
                end
            end else begin
                sw_wait++;
                if (!in_w) begin
                    sw_st = 0;
                end else if (sw_wait > 100) begin
                    chk("r_rel_timeout", in_w, 1'b0);
                    sw_st = 0;
                end
            end

            if (ts == 0) begin
                if (out_r) begin
                    if (txq.size() != 0) begin
                        tx_cur = txq.pop_front();
                        chk("t_flit", data_o, tx_cur);
                    end else begin
                        chk("t_spurious", out_r, 1'b0);
                    end
                    ts  = 1;
                    dly = $urandom_range(0, 3);
                end
            end else if (ts == 1) begin
                chk("t_hold", data_o, tx_cur);
                chk("t_req_hold", out_r, 1'b1);
                if (dly == 0) begin
                    out_w = 1'b1;
                    ts    = 2;
                    dly   = $urandom_range(0, 2);
                end else begin
                    dly--;
                end
            end else begin
                chk("t_req_drop", out_r, 1'b0);
                chk("t_rel_busy", tx_ready, 1'b0);
                if (dly == 0) begin
                    out_w = 1'b0;
                    ts    = 0;
                end else begin
                    dly--;
                end
            end

            tx_valid = (cyc < 2200) && ($urandom_range(0, 1) == 1);
            tx_addr  = 4'($urandom);
            tx_data  = 32'($urandom);
            if (tx_valid && tx_ready) txq.push_back({1'b1, tx_addr, tx_data});
        end
        tx_valid = 1'b0;
        chk("r_rxq_drained", 64'(rxq.size()), 64'(0));
        chk("r_txq_drained", 64'(txq.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/node_endpoint.md
NODE_ENDPOINT -- requirements
Module: node_endpoint

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, payload width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 4, node address width in bits.
REQ-003 SHALL have parameter ADDR, default 0, this node's own address.
REQ-004 SHALL have parameter CNT_SIZE, default 8, drop-counter width; localparam BUS_SIZE = DATA_SIZE+ADDR_SIZE+1.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port a_rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port tx_valid  input  1  user offers a word for transmission.
REQ-008 SHALL have port tx_addr  input  ADDR_SIZE  destination node of the offered word.
REQ-009 SHALL have port tx_data  input  DATA_SIZE  offered payload.
REQ-010 SHALL have port tx_ready  output  1  endpoint accepts the offered word this cycle.
REQ-011 SHALL have port out_r  output  1  flit on data_o is valid (request to switch local port).
REQ-012 SHALL have port out_w  input  1  switch acknowledges capture of data_o.
REQ-013 SHALL have port data_o  output  BUS_SIZE  outgoing flit.
REQ-014 SHALL have port in_r  input  1  switch presents a valid flit on data_i.
REQ-015 SHALL have port in_w  output  1  endpoint acknowledges capture of data_i.
REQ-016 SHALL have port data_i  input  BUS_SIZE  incoming flit.
REQ-017 SHALL have port rx_valid  output  1  rx_data holds a received word.
REQ-018 SHALL have port rx_ready  input  1  user consumes rx_data this cycle.
REQ-019 SHALL have port rx_data  output  DATA_SIZE  received payload.
REQ-020 SHALL have port drop_cnt  output  CNT_SIZE  count of discarded incoming flits.

Function
REQ-021 Flit format SHALL be {valid bit [BUS_SIZE-1], address [DATA_SIZE+:ADDR_SIZE], data [DATA_SIZE-1:0]}.
REQ-022 Both network directions SHALL use a 4-phase handshake: request high -> ack high -> request low -> ack low.
REQ-023 TX FSM SHALL have states T_IDLE, T_REQ, T_REL; tx_ready = 1 only in T_IDLE.
REQ-024 T_IDLE with tx_valid=1 SHALL latch {1'b1, tx_addr, tx_data} into data_o, set out_r=1 next cycle, go to T_REQ.
REQ-025 T_REQ SHALL hold out_r=1 and data_o stable until out_w=1 is sampled, then clear out_r next cycle and go to T_REL.
REQ-026 T_REL SHALL wait for out_w=0, then go to T_IDLE; a new word is not accepted before T_IDLE is re-entered.
REQ-027 Words with tx_addr==ADDR SHALL be transmitted unchanged (no local loopback).
REQ-028 RX side SHALL hold a 2-entry FIFO of payloads; rx_valid = FIFO non-empty; rx_data = head entry.
REQ-029 RX FSM SHALL have states R_IDLE, R_ACK; in R_IDLE with in_r=1 and FIFO count<2 (count at sampling edge, before any same-cycle pop), it captures data_i, sets in_w=1 next cycle, goes to R_ACK.
REQ-030 R_IDLE with in_r=1 and FIFO full SHALL keep in_w=0 (backpressure) until space exists.
REQ-031 R_ACK SHALL hold in_w=1 until in_r=0 is sampled, then clear in_w next cycle and return to R_IDLE.
REQ-032 A captured flit with valid bit 0 or address != ADDR SHALL be acknowledged normally but not written to the FIFO; drop_cnt increments by 1, saturating at 2^CNT_SIZE-1.
REQ-033 A pop (rx_valid & rx_ready) and a push in the same cycle SHALL both take effect; count unchanged.
REQ-034 TX and RX paths SHALL operate independently and concurrently.

Reset
REQ-035 a_rst=1 at a clock edge SHALL force T_IDLE, R_IDLE, out_r=0, in_w=0, data_o=0, FIFO empty (rx_valid=0), drop_cnt=0, also mid-handshake; tx_ready=1 from the first cycle after reset deasserts.

Verification
REQ-036 ADDR=3; tx_valid with tx_addr=5, tx_data=0xA5A5A5A5; switch acks 2 cycles after out_r -> data_o=0x15A5A5A5A5 held, out_r falls 1 cycle after out_w, tx_ready returns after out_w low.
REQ-037 Flit {1,3,0x12345678} with in_r -> in_w rises next cycle, rx_valid=1, rx_data=0x12345678; in_w falls 1 cycle after in_r low.
REQ-038 Flit addressed to 7 at ADDR=3 -> handshake completes, rx_valid stays 0, drop_cnt=1; with CNT_SIZE=2, 5 such flits -> drop_cnt=3.
REQ-039 rx_ready=0, three valid flits -> first two acked, third held with in_w=0; one pop -> third acked next cycle, order preserved.
REQ-040 a_rst asserted while out_r=1 and in_w=1 -> both 0 next cycle, FIFO empty, drop_cnt=0, tx_ready=1 after release.
